weight_buffer_fill_ctrl: RTL and testbench

WEIGHT_BUFFER_FILL_CTRL -- requirements
Module: weight_buffer_fill_ctrl

---
 rtl/weight_buffer_fill_ctrl.sv | 101 ++++++++++
 tb/tb_weight_buffer_fill_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/weight_buffer_fill_ctrl.sv
// Streams weight words into nb_pe_col buffer banks, filling column-major within each row.
// One word is written per accepted input, one cycle after acceptance.
module weight_buffer_fill_ctrl #(
  parameter int nb_pe_col         = 32,
  parameter int buffer_depth      = 72,
  parameter int buffer_width      = 16,
  parameter int buffer_addr_width = $clog2(buffer_depth)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic [buffer_addr_width:0]          nb_rows,
  input  logic [buffer_width-1:0]             in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [buffer_addr_width-1:0]        wAddr,
  output logic [nb_pe_col*buffer_width-1:0]   buffer_data_in,
  output logic [nb_pe_col-1:0]                buffer_wEn,
  output logic                                busy,
  output logic                                done
);

  localparam int COL_W = (nb_pe_col > 1) ? $clog2(nb_pe_col) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                     state, state_nxt;
  logic [COL_W-1:0]           col;
  logic [buffer_addr_width-1:0] row;
  logic [buffer_addr_width:0] rows_lat;
  logic [buffer_addr_width:0] rows_clamp;
  logic [nb_pe_col-1:0]       col_onehot;
  logic                       accept;
  logic                       last_col;
  logic                       last_row;

  assign accept     = in_valid && (state == FILL);
  assign last_col   = (col == COL_W'(nb_pe_col - 1));
  assign last_row   = ({1'b0, row} == (rows_lat - 1'b1));
  assign rows_clamp = (nb_rows > (buffer_addr_width+1)'(buffer_depth)) ?
                      (buffer_addr_width+1)'(buffer_depth) : nb_rows;

  assign in_ready = (state == FILL);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_comb begin
    col_onehot      = '0;
    col_onehot[col] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (nb_rows == '0) ? DONE : FILL;
      // abort wins over completion of the final word
      FILL: begin
        if (abort)
          state_nxt = IDLE;
        else if (accept && last_col && last_row)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write stage: the accepted word lands on the banks one cycle later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      col            <= '0;
      row            <= '0;
      rows_lat       <= '0;
      buffer_wEn     <= '0;
      wAddr          <= '0;
      buffer_data_in <= '0;
    end else begin
      state      <= state_nxt;
      buffer_wEn <= '0;
      if (state == IDLE && start) begin
        col      <= '0;
        row      <= '0;
        rows_lat <= rows_clamp;
      end
      if (accept) begin
        buffer_wEn     <= col_onehot;
        wAddr          <= row;
        buffer_data_in <= {nb_pe_col{in_data}};
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_buffer_fill_ctrl.sv
// Randomized bench for weight_buffer_fill_ctrl against a word-count based reference model.
module tb_weight_buffer_fill_ctrl;

  localparam int NC    = 32;
  localparam int DEPTH = 72;
  localparam int BW    = 16;
  localparam int AW    = 7;

  logic              clk = 1'b0;
  logic              rst_n, start, abort, in_valid;
  logic [AW:0]       nb_rows;
  logic [BW-1:0]     in_data;
  logic              in_ready, busy, done;
  logic [AW-1:0]     wAddr;
  logic [NC*BW-1:0]  buffer_data_in;
  logic [NC-1:0]     buffer_wEn;

  weight_buffer_fill_ctrl #(
    .nb_pe_col(NC), .buffer_depth(DEPTH), .buffer_width(BW), .buffer_addr_width(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .nb_rows(nb_rows),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .wAddr(wAddr),
    .buffer_data_in(buffer_data_in), .buffer_wEn(buffer_wEn), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0 idle, 1 filling, 2 done; progress kept as a word count
  int            m_phase, m_total, m_cnt, m_bank;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_data;

  int obs_wr, obs_done, obs_done_wr;
  int obs_first_bank, obs_first_addr, obs_last_bank, obs_last_addr;

  task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    bit acc;
    if (!rst_n) begin
      m_phase = 0; m_wr = 1'b0; m_addr = '0; m_data = '0;
      return;
    end
    acc  = (m_phase == 1) && in_valid;
    m_wr = acc;
    if (acc) begin
      m_bank = m_cnt % NC;
      m_addr = AW'(m_cnt / NC);
      m_data = in_data;
      m_cnt++;
    end
    case (m_phase)
      0: if (start) begin
        m_total = ((int'(nb_rows) > DEPTH) ? DEPTH : int'(nb_rows)) * NC;
        m_cnt   = 0;
        m_phase = (m_total == 0) ? 2 : 1;
      end
      1: begin
        if (abort) m_phase = 0;
        else if (acc && m_cnt == m_total) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic compare();
    logic [NC-1:0] ew;
    ew = '0;
    if (m_wr) ew[m_bank] = 1'b1;
    check("wen", buffer_wEn, ew);
    check("waddr", wAddr, m_addr);
    check("wdata", buffer_data_in, {NC{m_data}});
    check("in_ready", in_ready, m_phase == 1);
    check("busy", busy, m_phase != 0);
    check("done", done, m_phase == 2);
    if (buffer_wEn != '0) begin
      for (int i = 0; i < NC; i++) if (buffer_wEn[i]) obs_last_bank = i;
      obs_last_addr = int'(wAddr);
      if (obs_wr == 0) begin
        obs_first_bank = obs_last_bank;
        obs_first_addr = obs_last_addr;
      end
      obs_wr++;
      if (done) obs_done_wr++;
    end
    if (done) obs_done++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic run_fill(int rows, int prob, int abort_at, int rst_at);
    int budget;
    obs_wr = 0; obs_done = 0; obs_done_wr = 0;
    obs_first_bank = -1; obs_first_addr = -1; obs_last_bank = -1; obs_last_addr = -1;
    start = 1'b1; nb_rows = (AW+1)'(rows); in_valid = 1'b0; abort = 1'b0;
    cycle();
    start  = 1'b0;
    budget = 0;
    while (m_phase != 0 && budget < 10000) begin
      in_valid = ($urandom_range(0, 99) < prob);
      in_data  = BW'($urandom);
      start    = $urandom_range(0, 1) == 1;
      nb_rows  = (AW+1)'($urandom);
      abort    = (m_phase == 2) && ($urandom_range(0, 1) == 1);
      if (abort_at > 0 && m_phase == 1 && m_cnt == abort_at - 1 && in_valid) abort = 1'b1;
      if (rst_at > 0 && m_phase == 1 && m_cnt == rst_at) begin
        rst_n = 1'b0; start = 1'b1; abort = 1'b1;
        cycle();
        cycle();
        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
      end else begin
        cycle();
      end
      budget++;
    end
    check("timeout", budget < 10000, 1'b1);
    in_valid = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    int rows;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; nb_rows = '0;
    m_phase = 0; m_wr = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0; m_total = 0; m_bank = 0;
    obs_wr = 0; obs_done = 0; obs_done_wr = 0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    abort = 1'b1; in_valid = 1'b1;
    cycle();
    abort = 1'b0; in_valid = 1'b0;

    run_fill(2, 100, 0, 0);
    check("t2_writes", obs_wr, 64);
    check("t2_done", obs_done, 1);
    check("t2_done_last", obs_done_wr, 1);
    check("t2_last_bank", obs_last_bank, 31);
    check("t2_last_addr", obs_last_addr, 1);

    run_fill(0, 100, 0, 0);
    check("t0_writes", obs_wr, 0);
    check("t0_done", obs_done, 1);

    run_fill(3, 50, 0, 0);
    check("t3_writes", obs_wr, 96);
    check("t3_last_bank", obs_last_bank, 31);
    check("t3_last_addr", obs_last_addr, 2);

    run_fill(100, 100, 0, 0);
    check("clamp_writes", obs_wr, 2304);
    check("clamp_last_bank", obs_last_bank, 31);
    check("clamp_last_addr", obs_last_addr, 71);
    check("clamp_done", obs_done, 1);

    run_fill(2, 100, 40, 0);
    check("abort_writes", obs_wr, 40);
    check("abort_last_bank", obs_last_bank, 7);
    check("abort_last_addr", obs_last_addr, 1);
    check("abort_done", obs_done, 0);

    run_fill(1, 70, 0, 0);
    check("post_abort_bank", obs_first_bank, 0);
    check("post_abort_addr", obs_first_addr, 0);
    check("post_abort_writes", obs_wr, 32);

    run_fill(2, 100, 0, 50);
    check("rst_done", obs_done, 0);
    check("rst_writes", obs_wr, 50);
    run_fill(1, 100, 0, 0);
    check("post_rst_bank", obs_first_bank, 0);
    check("post_rst_addr", obs_first_addr, 0);

    for (int t = 0; t < 6; t++) begin
      rows = $urandom_range(0, 6);
      run_fill(rows, $urandom_range(20, 100), 0, 0);
      check("rand_writes", obs_wr, rows * NC);
      check("rand_done", obs_done, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
